// File: rtl/usb_transmitter.sv
// usb_transmitter: full-speed USB packet transmitter on clk48.
// Once started, it reads the packet bytes from the word-wide packet buffer.
// It sends SYNC, then the NRZI-encoded and bit-stuffed bytes, then EOP.
// Software supplies the complete packet (PID, payload, CRC) in the buffer.
// Ports:
//   clk48             - 48 MHz clock, the only clock
//   reset             - synchronous, active-high reset
//   start             - one-cycle transmit request, honoured only while idle
//   data_length       - packet length in bytes, sampled when start is accepted
//   buffer_address    - word address into the packet buffer
//   buffer_read_value - buffer word, valid one cycle after the address
//   usb_d_p_out/usb_d_n_out - D+/D- drive values
//   usb_output_enable - 1 while the block drives the pads
//   busy              - high while a transmission is in progress
//   done              - one-cycle pulse when a transmission completes
module usb_transmitter #(
    parameter int CLOCKS_PER_BIT         = 4,
    parameter int USB_PACKET_BUFFER_SIZE = 1024
) (
    input  logic                                        clk48,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [9:0]                                  data_length,
    output logic [$clog2(USB_PACKET_BUFFER_SIZE/4)-1:0] buffer_address,
    input  logic [31:0]                                 buffer_read_value,
    output logic                                        usb_d_p_out,
    output logic                                        usb_d_n_out,
    output logic                                        usb_output_enable,
    output logic                                        busy,
    output logic                                        done
);
    localparam int AW = $clog2(USB_PACKET_BUFFER_SIZE/4);
    localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_clk_cnt, w_clk_n;
    logic [2:0]      r_bit_idx, w_bit_n;    // next bit within SYNC/byte; EOP_SE0 bit count
    logic [9:0]      r_byte_idx, w_byte_n;  // bytes fully sent
    logic [9:0]      r_len, w_len_n;
    logic [2:0]      r_ones, w_ones_n;      // consecutive transmitted 1s
    logic            r_line, w_line_n;      // NRZI state, 1 = J
    logic            r_dp, r_dn, r_oe, r_busy, r_done;
    logic            w_dp_n, w_dn_n, w_oe_n, w_busy_n, w_done_n;
    logic            w_tick, w_start, w_emit, w_emit_bit, w_stuff, w_se0, w_word_adv, w_data_bit;

    // Buffer read side: r_word holds the word being sent, r_nword the prefetched one.
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_word, r_nword;
    logic            r_req, r_cap, r_have_cur;

    assign w_tick     = (r_clk_cnt == CW'(CLOCKS_PER_BIT - 1));
    assign w_start    = (r_state == S_IDLE) && start && (data_length != 10'd0);
    assign w_data_bit = r_word[{r_byte_idx[1:0], r_bit_idx}];

    always_comb begin
        w_state_n  = r_state;
        w_bit_n    = r_bit_idx;
        w_byte_n   = r_byte_idx;
        w_len_n    = r_len;
        w_ones_n   = r_ones;
        w_line_n   = r_line;
        w_dp_n     = r_dp;
        w_dn_n     = r_dn;
        w_oe_n     = r_oe;
        w_busy_n   = r_busy;
        w_done_n   = 1'b0;
        w_emit     = 1'b0;
        w_emit_bit = 1'b0;
        w_stuff    = 1'b0;
        w_se0      = 1'b0;
        w_word_adv = 1'b0;
        w_clk_n    = (r_state == S_IDLE || w_tick) ? '0 : r_clk_cnt + 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_n  = S_SYNC;
                    w_len_n    = data_length;
                    w_busy_n   = 1'b1;
                    w_oe_n     = 1'b1;
                    w_byte_n   = '0;
                    w_bit_n    = 3'd1;
                    w_emit     = 1'b1;
                    w_emit_bit = SYNC_BYTE[0];
                end
            end
            S_SYNC: begin
                if (w_tick) begin
                    // bit_idx wraps to 0 once all eight SYNC bits are out
                    if (r_bit_idx != 3'd0) begin
                        w_emit     = 1'b1;
                        w_emit_bit = SYNC_BYTE[r_bit_idx];
                        w_bit_n    = r_bit_idx + 3'd1;
                    end else begin
                        w_state_n  = S_DATA;
                        w_emit     = 1'b1;
                        w_emit_bit = w_data_bit;
                        w_bit_n    = 3'd1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    // stuff check comes first so a pending stuff bit precedes EOP
                    if (r_ones == 3'd6) begin
                        w_stuff = 1'b1;
                    end else if (r_byte_idx == r_len) begin
                        w_state_n = S_EOP_SE0;
                        w_se0     = 1'b1;
                        w_bit_n   = '0;
                    end else begin
                        w_emit     = 1'b1;
                        w_emit_bit = w_data_bit;
                        w_bit_n    = r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            w_byte_n = r_byte_idx + 10'd1;
                            if (r_byte_idx[1:0] == 2'd3) w_word_adv = 1'b1;
                        end
                    end
                end
            end
            S_EOP_SE0: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd0) begin
                        w_bit_n = 3'd1;
                    end else begin
                        w_state_n = S_EOP_J;
                        w_line_n  = 1'b1;
                        w_dp_n    = 1'b1;
                        w_dn_n    = 1'b0;
                    end
                end
            end
            S_EOP_J: begin
                if (w_tick) begin
                    w_state_n = S_IDLE;
                    w_oe_n    = 1'b0;
                    w_busy_n  = 1'b0;
                    w_done_n  = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // NRZI: a 0 toggles the line, a 1 holds it; a stuff bit is a forced 0
        if (w_emit) begin
            w_line_n = w_emit_bit ? r_line : ~r_line;
            w_ones_n = w_emit_bit ? r_ones + 3'd1 : 3'd0;
        end
        if (w_stuff) begin
            w_line_n = ~r_line;
            w_ones_n = 3'd0;
        end
        if (w_emit || w_stuff) begin
            w_dp_n = w_line_n;
            w_dn_n = ~w_line_n;
        end
        if (w_se0) begin
            w_dp_n = 1'b0;
            w_dn_n = 1'b0;
        end
    end

    always_ff @(posedge clk48) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_len      <= '0;
            r_ones     <= '0;
            r_line     <= 1'b1;
            r_dp       <= 1'b1;
            r_dn       <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_clk_cnt  <= w_clk_n;
            r_bit_idx  <= w_bit_n;
            r_byte_idx <= w_byte_n;
            r_len      <= w_len_n;
            r_ones     <= w_ones_n;
            r_line     <= w_line_n;
            r_dp       <= w_dp_n;
            r_dn       <= w_dn_n;
            r_oe       <= w_oe_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
        end
    end

    // Fetch pipeline: r_req marks the cycle a new address is presented,
    // r_cap the following cycle when the read data is valid.
    // Word 0 is loaded during SYNC, then word k+1 is prefetched while word k is sent.
    always_ff @(posedge clk48) begin
        if (reset) begin
            r_addr     <= '0;
            r_word     <= '0;
            r_nword    <= '0;
            r_req      <= 1'b0;
            r_cap      <= 1'b0;
            r_have_cur <= 1'b0;
        end else begin
            r_req <= 1'b0;
            r_cap <= r_req;
            if (w_start) begin
                r_addr     <= '0;
                r_req      <= 1'b1;
                r_have_cur <= 1'b0;
            end else if (w_word_adv) begin
                r_word <= r_nword;
                r_addr <= r_addr + 1'b1;
                r_req  <= 1'b1;
            end else if (r_cap) begin
                if (!r_have_cur) begin
                    r_word     <= buffer_read_value;
                    r_have_cur <= 1'b1;
                    r_addr     <= r_addr + 1'b1;
                    r_req      <= 1'b1;
                end else begin
                    r_nword <= buffer_read_value;
                end
            end
        end
    end

    assign buffer_address    = r_addr;
    assign usb_d_p_out       = r_dp;
    assign usb_d_n_out       = r_dn;
    assign usb_output_enable = r_oe;
    assign busy              = r_busy;
    assign done              = r_done;
endmodule

// File: tb/tb_usb_transmitter.sv
// Bench for usb_transmitter: table of packets with hand-computed line
// duration and byte contents, plus directed corner-case sequences.
module tb_usb_transmitter;
    logic        clk48 = 1'b0;
    logic        reset, start;
    logic [9:0]  data_length;
    logic [7:0]  buffer_address;
    logic [31:0] buffer_read_value;
    logic        dp, dn, oe, busy, done;

    usb_transmitter #(.CLOCKS_PER_BIT(4), .USB_PACKET_BUFFER_SIZE(1024)) dut (
        .clk48(clk48), .reset(reset), .start(start), .data_length(data_length),
        .buffer_address(buffer_address), .buffer_read_value(buffer_read_value),
        .usb_d_p_out(dp), .usb_d_n_out(dn), .usb_output_enable(oe),
        .busy(busy), .done(done)
    );

    always #5 clk48 = ~clk48;

    logic [31:0] mem [256];
    always @(posedge clk48) buffer_read_value <= mem[buffer_address];

    localparam logic [1:0] SJ = 2'b10, SK = 2'b01, S0 = 2'b00;

    typedef struct {
        string       name;
        int          len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_oe;
        logic [39:0] exp_bytes;   // byte i at [8*i +: 8]
    } vec_t;

    vec_t vec [7];
    int n_vec = 0, n_err = 0;
    logic [1:0] syms[$];
    int g_oe_cnt, g_done_at, g_dones, g_a1_at;
    logic [2:0] g_first;
    logic [1:0] ack_sym [19];
    logic [1:0] ff_sym  [20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string nm, input int len, input logic [31:0] w0,
                           input logic [31:0] w1, input int oe_c, input logic [39:0] b);
        vec[i].name = nm; vec[i].len = len; vec[i].w0 = w0; vec[i].w1 = w1;
        vec[i].exp_oe = oe_c; vec[i].exp_bytes = b;
    endtask

    task automatic pulse_start(input logic [9:0] len);
        @(negedge clk48);
        start = 1'b1;
        data_length = len;
        @(posedge clk48);
        #1 start = 1'b0;
    endtask

    // Samples on negedges from the cycle after the accepting edge; bounded.
    task automatic capture();
        int cyc = 0;
        g_oe_cnt = 0; g_done_at = -1; g_dones = 0; g_a1_at = -1; g_first = 3'b000;
        syms.delete();
        while (cyc < 3000) begin
            @(negedge clk48);
            cyc++;
            if (cyc == 1) g_first = {oe, busy, buffer_address == 8'd0};
            if (oe) begin
                syms.push_back({dp, dn});
                g_oe_cnt++;
            end
            if (buffer_address == 8'd1 && g_a1_at < 0) g_a1_at = cyc;
            if (done) begin
                g_dones++;
                if (g_done_at < 0) g_done_at = cyc;
            end
            if (g_done_at >= 0 && cyc >= g_done_at + 4) break;
        end
    endtask

    task automatic decode_check(input int i);
        int nb, hold_err, stuff_err, ones, idx;
        logic [1:0] prev, s;
        logic b;
        logic bits[$];
        logic [7:0] byt;
        nb = syms.size() / 4;
        hold_err = 0;
        for (int k = 0; k < syms.size(); k++)
            if (syms[k] !== syms[(k / 4) * 4]) hold_err++;
        chk({vec[i].name, " bit hold"}, hold_err, 0);
        if (nb < 4) return;
        chk({vec[i].name, " eop"}, {syms[(nb-3)*4], syms[(nb-2)*4], syms[(nb-1)*4]}, {S0, S0, SJ});
        prev = SJ; ones = 0; stuff_err = 0;
        for (int k = 0; k < nb - 3; k++) begin
            s = syms[k*4];
            b = (s == prev);
            prev = s;
            if (ones == 6) begin
                if (b) stuff_err++;
                ones = 0;
            end else begin
                bits.push_back(b);
                ones = b ? ones + 1 : 0;
            end
        end
        chk({vec[i].name, " stuff"}, stuff_err, 0);
        chk({vec[i].name, " bit count"}, bits.size(), 8 + 8 * vec[i].len);
        for (int j = 0; j < 8; j++) byt[j] = (j < bits.size()) ? bits[j] : 1'b0;
        chk({vec[i].name, " sync"}, byt, 8'h80);
        for (int n = 0; n < vec[i].len; n++) begin
            for (int j = 0; j < 8; j++) begin
                idx = 8 + 8 * n + j;
                byt[j] = (idx < bits.size()) ? bits[idx] : 1'b0;
            end
            chk($sformatf("%s byte%0d", vec[i].name, n), byt, vec[i].exp_bytes[8*n +: 8]);
        end
    endtask

    task automatic run_vec(input int i);
        mem[0] = vec[i].w0;
        mem[1] = vec[i].w1;
        pulse_start(10'(vec[i].len));
        capture();
        chk({vec[i].name, " first cycle oe/busy/addr0"}, g_first, 3'b111);
        chk({vec[i].name, " oe cycles"}, g_oe_cnt, vec[i].exp_oe);
        chk({vec[i].name, " done cycle"}, g_done_at, vec[i].exp_oe + 1);
        chk({vec[i].name, " done count"}, g_dones, 1);
        decode_check(i);
    endtask

    initial begin
        int mism, got;
        logic [2:0] acc;
        for (int a = 0; a < 256; a++) mem[a] = 32'hA5A50000 | a;
        set_vec(0, "ack",    1, 32'h000000D2, 32'h0,        76, 40'hD2);
        set_vec(1, "ff",     1, 32'h000000FF, 32'h0,        80, 40'hFF);
        set_vec(2, "order5", 5, 32'h44332211, 32'h000000AA, 204, 40'hAA44332211);
        set_vec(3, "ffff",   2, 32'h0000FFFF, 32'h0,        116, 40'hFFFF);
        set_vec(4, "fc_end", 1, 32'h000000FC, 32'h0,        80, 40'hFC);
        set_vec(5, "7e_x4",  4, 32'h7E7E7E7E, 32'h0,        188, 40'h7E7E7E7E);
        set_vec(6, "len4",   4, 32'h78563412, 32'h0,        172, 40'h78563412);
        ack_sym = '{SK,SJ,SK,SJ,SK,SJ,SK,SK, SJ,SJ,SK,SJ,SJ,SK,SK,SK, S0,S0,SJ};
        ff_sym  = '{SK,SJ,SK,SJ,SK,SJ,SK,SK, SK,SK,SK,SK,SK,SJ,SJ,SJ,SJ, S0,S0,SJ};

        reset = 1'b1; start = 1'b0; data_length = 10'd0;
        repeat (2) @(posedge clk48);
        @(negedge clk48);
        chk("reset state oe/dp/dn/busy/done", {oe, dp, dn, busy, done}, 5'b01000);
        chk("reset address", buffer_address, 8'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
            if (i == 0) begin
                mism = 0;
                for (int b = 0; b < 19; b++) if (syms[b*4] !== ack_sym[b]) mism++;
                chk("ack symbols", mism, 0);
            end
            if (i == 1) begin
                mism = 0;
                for (int b = 0; b < 20; b++) if (syms[b*4] !== ff_sym[b]) mism++;
                chk("ff symbols", mism, 0);
            end
            if (i == 2) chk("word1 address before byte4", (g_a1_at > 0) && (g_a1_at < 161), 1);
        end

        // zero length is ignored
        pulse_start(10'd0);
        acc = 3'b000;
        repeat (10) begin
            @(negedge clk48);
            acc = acc | {oe, busy, done};
        end
        chk("zero length oe/busy/done", acc, 3'b000);

        // second start mid-packet is ignored
        mem[0] = 32'h000000D2;
        pulse_start(10'd1);
        fork
            capture();
            begin
                repeat (20) @(negedge clk48);
                start = 1'b1; data_length = 10'd3;
                @(posedge clk48);
                #1 start = 1'b0;
            end
        join
        chk("busy start oe cycles", g_oe_cnt, 76);
        chk("busy start done count", g_dones, 1);

        // start on the done cycle is accepted
        pulse_start(10'd1);
        got = 0;
        for (int c = 0; c < 200 && got == 0; c++) begin
            @(negedge clk48);
            if (done) got = 1;
        end
        chk("done before chained start", got, 1);
        start = 1'b1; data_length = 10'd1;
        @(posedge clk48);
        #1 start = 1'b0;
        @(negedge clk48);
        chk("start on done cycle oe/busy/done", {oe, busy, done}, 3'b110);
        capture();
        chk("chained oe cycles", g_oe_cnt, 75);
        chk("chained done count", g_dones, 1);

        // reset during byte 2 of a 4-byte packet
        mem[0] = 32'h78563412;
        pulse_start(10'd4);
        repeat (105) @(negedge clk48);
        chk("pre-reset oe", oe, 1'b1);
        reset = 1'b1;
        @(negedge clk48);
        chk("mid reset oe/dp/dn/busy/done", {oe, dp, dn, busy, done}, 5'b01000);
        reset = 1'b0;
        acc = 3'b000;
        repeat (20) begin
            @(negedge clk48);
            acc = acc | {oe, busy, done};
        end
        chk("after reset quiet", acc, 3'b000);
        run_vec(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/usb_transmitter.md
Name: usb_transmitter

Overview:
Full-speed USB (12 Mbit/s) packet transmitter on the clk48 domain. It is the send-side counterpart of the receive path that fills the USB packet buffer.
- On a start request it reads bytes from the word-wide USB packet buffer through a read port.
- It prepends SYNC, then NRZI-encodes and bit-stuffs the bytes, appends EOP, and drives the D+/D- pads through an output enable.
- Software places the complete packet in the buffer (PID, payload, CRC). The block computes no CRC.

Parameters:
CLOCKS_PER_BIT, 4, clk48 cycles per USB bit time (48 MHz / 12 MHz).
USB_PACKET_BUFFER_SIZE, 1024, buffer size in bytes; word address width is $clog2(USB_PACKET_BUFFER_SIZE/4).

Ports:
clk48  input  1  48 MHz clock; the only clock.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to transmit; honoured only while idle.
data_length  input  10  packet length in bytes; sampled on the accepted start cycle.
buffer_address  output  $clog2(USB_PACKET_BUFFER_SIZE/4)  word address into the packet buffer.
buffer_read_value  input  32  buffer word; valid one clk48 cycle after buffer_address is presented.
usb_d_p_out  output  1  D+ drive value.
usb_d_n_out  output  1  D- drive value.
usb_output_enable  output  1  1 = block drives the pads.
busy  output  1  high while a transmission is in progress.
done  output  1  one-cycle pulse when a transmission completes.

Behaviour:
- Interface: one clock (clk48); reset is synchronous and active-high.
- Line states: J = (d_p=1, d_n=0); K = (0,1); SE0 = (0,0).
- Reset values: usb_output_enable=0, usb_d_p_out=1, usb_d_n_out=0, busy=0, done=0, buffer_address=0.
- All outputs are registered.
- States: IDLE -> SYNC -> DATA -> EOP_SE0 -> EOP_J -> IDLE.
- IDLE:
  - Drives J with oe=0.
  - start=1 with data_length!=0: latch the length, set busy, enter SYNC.
  - start=1 with data_length=0: ignored; no busy, no done.
  - start while busy: ignored.
- Start latency: start accepted on cycle N. On cycle N+1, oe=1, busy=1, and the first SYNC bit is on the line.
- Bit timing:
  - Every bit, including stuff and EOP bits, holds exactly CLOCKS_PER_BIT cycles.
  - Line outputs change only on bit boundaries.
- SYNC: byte 0x80, sent LSB first.
- NRZI: the line state entering SYNC is J. Data 0 toggles J<->K; data 1 holds the state.
- Bit stuffing:
  - A ones counter runs over SYNC and DATA. It counts consecutive transmitted 1 data bits; the SYNC final 1 counts.
  - After six consecutive 1s, insert a 0 bit (a transition) and reset the counter. Any 0 also resets the counter.
  - A stuff bit required after the last data bit is sent before EOP.
- DATA:
  - Bytes 0..length-1 are sent in order, each LSB first.
  - Byte i = word (i>>2), bits [8*(i&3)+7 : 8*(i&3)].
  - Each word is fetched at least 2 cycles before its first bit is needed. Reading begins during SYNC.
  - buffer_address wraps naturally at the address width.
- EOP: SE0 for 2 bit times (EOP_SE0), then J for 1 bit time (EOP_J).
- Completion:
  - On the cycle after EOP_J ends: oe=0, busy=0, done=1 for exactly one cycle, state IDLE.
  - A start on the done cycle is accepted.
- Duration: with no stuffing, oe stays high for CLOCKS_PER_BIT*(8*length+11) cycles. Each stuff bit adds CLOCKS_PER_BIT.
- Reset mid-transmission: next edge gives reset values, no done pulse, ones counter and byte index cleared.

Test Plan:
- Reset idle: assert reset 2 cycles -> oe=0, d_p=1, d_n=0, busy=0, done=0.
- ACK: length=1, word0=0x000000D2, start on cycle N.
  - Line from N+1, 4 cycles per symbol: K J K J K J K K, J J K J J K K K, SE0 SE0 J.
  - oe high 76 cycles; done pulses at N+77.
- Stuffing: length=1, byte 0xFF.
  - Stuff 0 inserted after the 5th bit of the byte, giving K J K J K J K K, K K K K K J J J J, SE0 SE0 J.
  - oe high 80 cycles.
- Byte order / prefetch: length=5, word0=0x44332211, word1=0x000000AA.
  - Decoded bytes 11 22 33 44 AA in order.
  - buffer_address 0 then 1, each presented before the first bit of its word.
- Length zero and start while busy:
  - start with length=0 -> no oe, no busy, no done.
  - Second start mid-packet -> ignored; one done only.
- Reset mid-DATA: reset asserted during byte 2 of a 4-byte packet -> next cycle oe=0, J, busy=0, no done. A fresh start sends a complete correct packet.
